// File: rtl/tile_engine.sv
// tile_engine: falling-tile rhythm game core (step timer, tile scroller, press judge, scoring).
// Optional macro TILE_ENGINE_MISS_TOLERANCE_EN gives the player two lives before game over.
module tile_engine #(
    parameter int LANES   = 4,
    parameter int DEPTH   = 5,
    parameter int HIT_ROW = 3,
    parameter int PER_W   = 12,
    parameter int SCORE_W = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [LANES-1:0]         btn,
    input  logic [LANES-1:0]         rand_bits,
    input  logic [PER_W-1:0]         period,
    output logic [LANES*DEPTH-1:0]   tiles,
    output logic [LANES-1:0]         press_mask,
    output logic                     step,
    output logic [SCORE_W-1:0]       score,
    output logic [1:0]               level,
    output logic                     playing,
    output logic                     game_over
);

    typedef enum logic [1:0] {IDLE, ARM, PLAY, OVER} state_t;

    state_t               state, state_nxt;
    logic                 start_d, start_rise;
    logic [LANES-1:0]     btn_d, rise;
    logic [PER_W-1:0]     cnt;
    logic [1:0]           lvl_run;
    logic [PER_W+1:0]     reduce, diff, eff;
    logic                 last;
    logic [2:0]           over_steps;
    logic [LANES-1:0]     hit_row, new_row;
    logic [3:0]           hit_count;
    logic [SCORE_W:0]     score_sum;
    logic                 judge_pass, miss_fatal;
    logic                 enter_arm, enter_over, shift_en;
`ifdef TILE_ENGINE_MISS_TOLERANCE_EN
    logic [1:0]           lives;
`endif

    assign playing = (state == PLAY);

    always_comb begin
        level = 2'd2;
        if (score < SCORE_W'(10))
            level = 2'd0;
        else if (score < SCORE_W'(40))
            level = 2'd1;
    end

    // Step length uses the level latched at the last wrap, so speed-ups never cut a window short.
    always_comb begin
        reduce = (PER_W+2)'(period >> 3) * (PER_W+2)'(lvl_run);
        diff   = {2'b00, period} - reduce;
        eff    = (diff == '0) ? (PER_W+2)'(1) : diff;
        last   = ({2'b00, cnt} >= eff - (PER_W+2)'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        enter_arm  = 1'b0;
        enter_over = 1'b0;
        shift_en   = 1'b0;
        new_row    = '0;
        start_rise = start & ~start_d;
        rise       = btn & ~btn_d;
        hit_row    = tiles[HIT_ROW*LANES +: LANES];
        judge_pass = (press_mask == hit_row);
        hit_count  = '0;
        for (int i = 0; i < LANES; i++)
            hit_count = hit_count + 4'(hit_row[i]);
        score_sum  = {1'b0, score} + (SCORE_W+1)'(hit_count);
`ifdef TILE_ENGINE_MISS_TOLERANCE_EN
        miss_fatal = ~judge_pass && (lives == 2'd1);
`else
        miss_fatal = ~judge_pass;
`endif
        case (state)
            IDLE: begin
                shift_en = 1'b1;
                if (start_rise) begin
                    state_nxt = ARM;
                    enter_arm = 1'b1;
                end
            end
            ARM: begin
                shift_en = 1'b1;
                if (step && !start)
                    state_nxt = PLAY;
            end
            PLAY: begin
                new_row = rand_bits;
                if (step && miss_fatal) begin
                    state_nxt  = OVER;
                    enter_over = 1'b1;
                end else begin
                    shift_en = 1'b1;
                end
            end
            OVER: begin
                if (step && over_steps == 3'd7)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The fatal step leaves the losing board in place; OVER then holds everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_d    <= 1'b0;
            btn_d      <= '0;
            cnt        <= '0;
            step       <= 1'b0;
            lvl_run    <= '0;
            tiles      <= '0;
            press_mask <= '0;
            score      <= '0;
            over_steps <= '0;
            game_over  <= 1'b0;
`ifdef TILE_ENGINE_MISS_TOLERANCE_EN
            lives      <= 2'd0;
`endif
        end else begin
            start_d   <= start;
            btn_d     <= btn;
            game_over <= enter_over;
            if (enter_arm) begin
                cnt        <= '0;
                step       <= 1'b0;
                lvl_run    <= '0;
                tiles      <= '0;
                press_mask <= '0;
                score      <= '0;
`ifdef TILE_ENGINE_MISS_TOLERANCE_EN
                lives      <= 2'd2;
`endif
            end else begin
                cnt  <= last ? '0 : cnt + PER_W'(1);
                step <= last;
                if (last)
                    lvl_run <= level;
                if (state != OVER)
                    press_mask <= step ? rise : (press_mask | rise);
                if (step && shift_en)
                    tiles <= {tiles[(DEPTH-1)*LANES-1:0], new_row};
                if (step && state == PLAY) begin
                    if (judge_pass)
                        score <= score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
`ifdef TILE_ENGINE_MISS_TOLERANCE_EN
                    else if (lives != 2'd0)
                        lives <= lives - 2'd1;
`endif
                end
                if (enter_over)
                    over_steps <= '0;
                else if (step && state == OVER)
                    over_steps <= over_steps + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_tile_engine.sv
// tb_tile_engine: randomized self-checking bench for tile_engine against a step-level game model.
// Builds with or without TILE_ENGINE_MISS_TOLERANCE_EN; the model follows the same macro.
module tb_tile_engine;

    localparam int LANES   = 4;
    localparam int DEPTH   = 5;
    localparam int HIT_ROW = 3;
    localparam int PER_W   = 12;
    localparam int SCORE_W = 12;
    localparam int SMAX    = (1 << SCORE_W) - 1;
    localparam int WB      = 300;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   start = 1'b0;
    logic [LANES-1:0]       btn = '0;
    logic [LANES-1:0]       rand_bits = '0;
    logic [PER_W-1:0]       period = PER_W'(4);
    logic [LANES*DEPTH-1:0] tiles;
    logic [LANES-1:0]       press_mask;
    logic                   step;
    logic [SCORE_W-1:0]     score;
    logic [1:0]             level;
    logic                   playing;
    logic                   game_over;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_step_cyc = 0;
    int exp_gap = -1;

    logic [LANES-1:0] mrow [DEPTH];
    logic [LANES-1:0] mpm;
    int               mscore;
    int               mlives;
    bit               mplay = 1'b0;

    tile_engine #(
        .LANES(LANES), .DEPTH(DEPTH), .HIT_ROW(HIT_ROW), .PER_W(PER_W), .SCORE_W(SCORE_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .btn(btn), .rand_bits(rand_bits),
        .period(period), .tiles(tiles), .press_mask(press_mask), .step(step),
        .score(score), .level(level), .playing(playing), .game_over(game_over)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    function automatic int popcnt(input logic [LANES-1:0] v);
        int n = 0;
        for (int i = 0; i < LANES; i++) n += int'(v[i]);
        return n;
    endfunction

    function automatic int levelOf(input int s);
        return (s < 10) ? 0 : (s < 40) ? 1 : 2;
    endfunction

    function automatic int effOf(input int p, input int l);
        int d = p - l * (p / 8);
        return (d < 1) ? 1 : d;
    endfunction

    function automatic logic [LANES*DEPTH-1:0] packTiles();
        logic [LANES*DEPTH-1:0] t = '0;
        for (int r = 0; r < DEPTH; r++) t[r*LANES +: LANES] = mrow[r];
        return t;
    endfunction

    function automatic logic [LANES-1:0] pickRow(input int mode, input int k);
        case (mode)
            0:       return LANES'($urandom);
            1:       return LANES'(1);
            2:       return '1;
            3:       return LANES'(7);
            default: return (k % 4 == 0) ? LANES'(4) : '0;
        endcase
    endfunction

    task automatic waitStep();
        int n = 0;
        while (step !== 1'b1 && n < WB) begin
            @(negedge clk);
            n++;
        end
        if (step !== 1'b1)
            checkOutput("step_timeout", step, 1);
        else if (exp_gap > 0)
            checkOutput("step_gap", cyc - last_step_cyc, exp_gap);
        last_step_cyc = cyc;
    endtask

    // Called at the negedge of a step cycle: judge, scroll, then press for the next judgement.
    task automatic doStep(input logic [LANES-1:0] row_in, input int miss_kind);
        bit pass;
        bit fatal = 1'b0;
        logic [LANES-1:0] target, press;
        checkOutput("press_mask", press_mask, mpm);
        checkOutput("tiles", tiles, packTiles());
        rand_bits = row_in;
        pass = (mpm == mrow[HIT_ROW]);
        exp_gap = effOf(int'(period), levelOf(mscore));
        if (pass) begin
            mscore = mscore + popcnt(mrow[HIT_ROW]);
            if (mscore > SMAX) mscore = SMAX;
        end else begin
            mlives--;
            fatal = (mlives == 0);
        end
        if (!fatal) begin
            for (int r = DEPTH - 1; r > 0; r--) mrow[r] = mrow[r-1];
            mrow[0] = row_in;
        end
        @(negedge clk);
        checkOutput("game_over", game_over, fatal);
        checkOutput("playing", playing, !fatal);
        checkOutput("score", score, mscore);
        checkOutput("level", level, levelOf(mscore));
        mpm = '0;
        mplay = !fatal;
        if (!fatal) begin
            target = mrow[HIT_ROW];
            case (miss_kind)
                1:       press = target ^ (LANES'(1) << $urandom_range(LANES - 1, 0));
                2:       press = LANES'(2);
                default: press = target;
            endcase
            btn = press;
            mpm = press;
        end
        @(negedge clk);
        btn = '0;
    endtask

    task automatic startGame();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("arm_score", score, 0);
        checkOutput("arm_tiles", tiles, 0);
        checkOutput("arm_press", press_mask, 0);
        checkOutput("arm_playing", playing, 0);
        exp_gap = -1;
        waitStep();
        exp_gap = effOf(int'(period), 0);
        @(negedge clk);
        checkOutput("play_entry", playing, 1);
        for (int r = 0; r < DEPTH; r++) mrow[r] = '0;
        mpm = '0;
        mscore = 0;
`ifdef TILE_ENGINE_MISS_TOLERANCE_EN
        mlives = 2;
`else
        mlives = 1;
`endif
        mplay = 1'b1;
    endtask

    task automatic applyStimulus(input int n, input int mode, input int miss_a, input int miss_b,
                                 input int kind);
        for (int k = 0; k < n && mplay; k++) begin
            waitStep();
            doStep(pickRow(mode, k), (k == miss_a || k == miss_b) ? kind : 0);
        end
    endtask

    task automatic playUntil(input int mode, input int target, input int maxn);
        for (int k = 0; k < maxn && mplay && mscore < target; k++) begin
            waitStep();
            doStep(pickRow(mode, k), 0);
        end
    endtask

    // OVER holds board, score and press_mask for 8 steps; the next step is in IDLE and scrolls zeros in.
    task automatic checkOver();
        logic [LANES*DEPTH-1:0] frozen = packTiles();
        checkOutput("game_over_width", game_over, 0);
        btn = '1;
        start = 1'b1;
        @(negedge clk);
        btn = '0;
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_gap = effOf(int'(period), levelOf(mscore));
            waitStep();
            checkOutput("over_tiles", tiles, frozen);
            checkOutput("over_score", score, mscore);
            checkOutput("over_press", press_mask, 0);
            @(negedge clk);
        end
        waitStep();
        checkOutput("last_over_tiles", tiles, frozen);
        @(negedge clk);
        frozen = frozen << LANES;
        checkOutput("idle_scroll", tiles, frozen);
        checkOutput("idle_score", score, mscore);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        checkOutput("rst_tiles", tiles, 0);
        checkOutput("rst_step", step, 0);
        checkOutput("rst_score", score, 0);
        checkOutput("rst_playing", playing, 0);
        checkOutput("rst_game_over", game_over, 0);
        rst_n = 1'b1;

        period = PER_W'(4);
        startGame();
        applyStimulus(8, 1, -1, -1, 0);
        applyStimulus(10, 0, 2, 6, 1);
        if (!mplay) checkOver();

        startGame();
        applyStimulus(12, 4, 3, 7, 2);
        if (!mplay) checkOver();

        @(negedge clk);
        period = PER_W'(64);
        startGame();
        playUntil(0, 45, 150);
        applyStimulus(3, 2, -1, -1, 0);

        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_tiles", tiles, 0);
        checkOutput("midrst_press", press_mask, 0);
        checkOutput("midrst_score", score, 0);
        checkOutput("midrst_level", level, 0);
        checkOutput("midrst_step", step, 0);
        checkOutput("midrst_playing", playing, 0);
        checkOutput("midrst_game_over", game_over, 0);
        mplay = 1'b0;
        @(negedge clk);
        period = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            checkOutput("period0_step", step, 1);
            @(negedge clk);
        end

        period = PER_W'(2);
        startGame();
        playUntil(2, 4080, 1100);
        applyStimulus(12, 3, -1, -1, 0);
        checkOutput("score_saturated", score, SMAX);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
